// File: rtl/sram_resp_pkg.sv
// Shared definitions for the SRAM responder: MMIO register offsets, the
// default MMIO window placement and an offset decoder used by the MMIO block.
package sram_resp_pkg;

  // Register offsets inside the MMIO window (byte offsets, addr[15:0])
  localparam logic [15:0] TIMER_OFF   = 16'h0000;
  localparam logic [15:0] LED_OFF     = 16'h0004;
  localparam logic [15:0] NUM_OFF     = 16'h0008;
  localparam logic [15:0] SCRATCH_OFF = 16'h000C;

  // Default MMIO window: any data address whose masked value equals the base
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;
  localparam logic [31:0] MMIO_MASK_DEFAULT = 32'hFFFF_0000;

  // One-of register select produced by the offset decoder
  typedef enum logic [2:0] {
    REG_TIMER,
    REG_LED,
    REG_NUM,
    REG_SCRATCH,
    REG_NONE
  } mmio_reg_e;

  // Map a window offset onto the register it addresses; holes map to REG_NONE
  function automatic mmio_reg_e decode_offset(input logic [15:0] off);
    mmio_reg_e r;
    case (off)
      TIMER_OFF:   r = REG_TIMER;
      LED_OFF:     r = REG_LED;
      NUM_OFF:     r = REG_NUM;
      SCRATCH_OFF: r = REG_SCRATCH;
      default:     r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_resp_mmio.sv
// MMIO register block of the SRAM responder: free-running timer, LED, NUM and
// SCRATCH registers plus the combinational read mux. The read mux reflects the
// register values before the current edge, so a TIMER read returns the value
// sampled at the request edge (pre-increment).
module sram_resp_mmio
  import sram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        we,
  input  logic [15:0] offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_comb,
  output logic [15:0] led,
  output logic [31:0] num_data,
  output mmio_reg_e   reg_hit
);

  logic [31:0] timer;
  logic [31:0] scratch;
  logic        wr_en;

  assign reg_hit = decode_offset(offset);
  assign wr_en   = sel & we;

  // Timer: counts every cycle and wraps; a write loads it and wins over the increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (wr_en && (reg_hit == REG_TIMER)) begin
      timer <= wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  // LED / NUM / SCRATCH: plain full-word (LED: low half) writable registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led      <= '0;
      num_data <= '0;
      scratch  <= '0;
    end else if (wr_en) begin
      case (reg_hit)
        REG_LED:     led      <= wdata[15:0];
        REG_NUM:     num_data <= wdata;
        REG_SCRATCH: scratch  <= wdata;
        default:     ;
      endcase
    end
  end

  // Read mux; unmapped offsets read as zero
  always_comb begin
    rdata_comb = '0;
    case (reg_hit)
      REG_TIMER:   rdata_comb = timer;
      REG_LED:     rdata_comb = {16'h0000, led};
      REG_NUM:     rdata_comb = num_data;
      REG_SCRATCH: rdata_comb = scratch;
      default:     rdata_comb = '0;
    endcase
  end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the CPU's instruction and data SRAM ports.
// Both ports share one word-addressed array; the data port additionally
// decodes an MMIO window (timer, LED, NUM, SCRATCH).
// Optional build macro: MEM_INIT_EN clears the array at time zero.
//
// Request protocol (both ports): at a rising clock edge, en=1 qualifies a
// request and we selects write (1) or read (0). There is no ready signal:
// every request completes in the cycle it is presented. Read data appears on
// rdata right after that edge and holds until the next read on the same port.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter logic [31:0] MMIO_MASK = MMIO_MASK_DEFAULT,
  parameter              INIT_FILE = "inst_ram.mif"
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic        inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int unused_init_bits = $bits(INIT_FILE);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] inst_idx;
  logic [ADDR_W-1:0] data_idx;
  logic              data_is_mmio;
  logic              mmio_sel;
  logic              inst_mem_we;
  logic              data_mem_we;
  logic [31:0]       mmio_rdata;
  mmio_reg_e         mmio_reg_hit;

  // Byte-offset and high address bits do not select a word; accesses alias
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_sram_addr[1:0], inst_sram_addr[31:ADDR_W+2],
                              data_sram_addr[1:0], mmio_reg_hit};

  assign inst_idx     = inst_sram_addr[ADDR_W+1:2];
  assign data_idx     = data_sram_addr[ADDR_W+1:2];
  assign data_is_mmio = ((data_sram_addr & MMIO_MASK) == MMIO_BASE);
  assign mmio_sel     = data_sram_en & data_is_mmio;
  assign inst_mem_we  = inst_sram_en & inst_sram_we;
  assign data_mem_we  = data_sram_en & data_sram_we & ~data_is_mmio;

`ifdef MEM_INIT_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end
`endif

  // Array writes; the data port is applied last so it wins a same-word clash
  always_ff @(posedge clk) begin
    if (inst_mem_we) begin
      mem[inst_idx] <= inst_sram_wdata;
    end
    if (data_mem_we) begin
      mem[data_idx] <= data_sram_wdata;
    end
  end

  // Instruction read register: samples the array before this edge's writes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_sram_rdata <= '0;
    end else if (inst_sram_en && !inst_sram_we) begin
      inst_sram_rdata <= mem[inst_idx];
    end
  end

  // Data read register: MMIO mux or array, sampled before this edge's writes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_rdata <= '0;
    end else if (data_sram_en && !data_sram_we) begin
      data_sram_rdata <= data_is_mmio ? mmio_rdata : mem[data_idx];
    end
  end

  sram_resp_mmio u_mmio (
    .clk        (clk),
    .resetn     (resetn),
    .sel        (mmio_sel),
    .we         (data_sram_we),
    .offset     (data_sram_addr[15:0]),
    .wdata      (data_sram_wdata),
    .rdata_comb (mmio_rdata),
    .led        (led),
    .num_data   (num_data),
    .reg_hit    (mmio_reg_hit)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed memory/MMIO scenarios plus
// a short randomized write/readback pass, with per-port expected-read queues.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_en = 1'b0;
  logic        inst_sram_we = 1'b0;
  logic [31:0] inst_sram_addr = '0;
  logic [31:0] inst_sram_wdata = '0;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic        data_sram_we = 1'b0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num_data;

  localparam logic [31:0] TIMER_A   = 32'hBFAF_0000;
  localparam logic [31:0] LED_A     = 32'hBFAF_0004;
  localparam logic [31:0] NUM_A     = 32'hBFAF_0008;
  localparam logic [31:0] SCRATCH_A = 32'hBFAF_000C;
  localparam logic [31:0] HOLE_A    = 32'hBFAF_0010;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .num_data        (num_data)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];
  string       tag_inst_q[$];
  string       tag_data_q[$];
  logic [31:0] last_inst = '0;
  logic [31:0] last_data = '0;
  int          edges_since_rel = 0;
  logic [31:0] model_mem [int];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic inst_read(input logic [31:0] a, input logic [31:0] e, input string tag);
    inst_sram_en = 1'b1; inst_sram_we = 1'b0; inst_sram_addr = a;
    exp_inst_q.push_back(e); tag_inst_q.push_back(tag);
  endtask

  task automatic inst_write(input logic [31:0] a, input logic [31:0] d);
    inst_sram_en = 1'b1; inst_sram_we = 1'b1; inst_sram_addr = a; inst_sram_wdata = d;
  endtask

  task automatic data_read(input logic [31:0] a, input logic [31:0] e, input string tag);
    data_sram_en = 1'b1; data_sram_we = 1'b0; data_sram_addr = a;
    exp_data_q.push_back(e); tag_data_q.push_back(tag);
  endtask

  task automatic data_write(input logic [31:0] a, input logic [31:0] d);
    data_sram_en = 1'b1; data_sram_we = 1'b1; data_sram_addr = a; data_sram_wdata = d;
  endtask

  // One clock: sample #1 after the edge, pop/compare reads, check holds, idle ports
  task automatic step();
    bit ir;
    bit dr;
    logic [31:0] e;
    string t;
    ir = inst_sram_en && !inst_sram_we;
    dr = data_sram_en && !data_sram_we;
    @(posedge clk);
    #1;
    if (resetn) edges_since_rel++;
    if (ir && exp_inst_q.size() > 0) begin
      e = exp_inst_q.pop_front(); t = tag_inst_q.pop_front();
      check_val(t, inst_sram_rdata, e);
      last_inst = e;
    end else begin
      check_val("inst_hold", inst_sram_rdata, last_inst);
    end
    if (dr && exp_data_q.size() > 0) begin
      e = exp_data_q.pop_front(); t = tag_data_q.pop_front();
      check_val(t, data_sram_rdata, e);
      last_data = e;
    end else begin
      check_val("data_hold", data_sram_rdata, last_data);
    end
    inst_sram_en = 1'b0; inst_sram_we = 1'b0;
    data_sram_en = 1'b0; data_sram_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          w;
    logic [31:0] d;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_inst_rdata", inst_sram_rdata, 32'h0);
    check_val("rst_data_rdata", data_sram_rdata, 32'h0);
    check_val("rst_led", {16'h0, led}, 32'h0);
    check_val("rst_num", num_data, 32'h0);

    // Timer starts at 0 after release and counts one per edge
    resetn = 1'b1;
    edges_since_rel = 0;
    data_read(TIMER_A, 32'(edges_since_rel), "timer_first"); step();
    repeat (4) step();
    data_read(TIMER_A, 32'(edges_since_rel), "timer_count5"); step();

    // Memory write via data port, read via instruction port, aliasing
    data_write(32'h0000_0100, 32'hDEAD_BEEF); step();
    inst_read(32'h0000_0100, 32'hDEAD_BEEF, "inst_rd_100"); step();
    inst_read(32'h0000_0101, 32'hDEAD_BEEF, "inst_rd_101_alias"); step();
    inst_read(32'h0001_0100, 32'hDEAD_BEEF, "inst_rd_high_alias"); step();

    // Read-before-write in both directions, and data-port priority on write clash
    inst_write(32'h40, 32'hAAAA_5555); step();
    inst_read(32'h40, 32'hAAAA_5555, "rbw_inst_old"); data_write(32'h40, 32'h0000_1234); step();
    inst_read(32'h40, 32'h0000_1234, "rbw_inst_new"); step();
    data_read(32'h40, 32'h0000_1234, "rbw_data_old"); inst_write(32'h40, 32'h0000_5678); step();
    data_read(32'h40, 32'h0000_5678, "rbw_data_new"); step();
    inst_write(32'h80, 32'h1111_1111); data_write(32'h80, 32'h2222_2222); step();
    inst_read(32'h80, 32'h2222_2222, "ww_data_wins"); step();

    // MMIO registers; word 0x8 of memory aliases the NUM offset
    data_write(32'h0000_0008, 32'hCAFE_0008); step();
    data_write(LED_A, 32'hFFFF_A5A5); step();
    check_val("led_out", {16'h0, led}, 32'h0000_A5A5);
    data_read(LED_A, 32'h0000_A5A5, "led_rd"); step();
    data_write(NUM_A, 32'h0000_0007); step();
    check_val("num_out", num_data, 32'h0000_0007);
    data_read(NUM_A, 32'h0000_0007, "num_rd"); step();
    data_write(SCRATCH_A, 32'h1357_9BDF); step();
    data_read(SCRATCH_A, 32'h1357_9BDF, "scratch_rd"); step();
    data_write(HOLE_A, 32'hFFFF_FFFF); step();
    check_val("hole_wr_led", {16'h0, led}, 32'h0000_A5A5);
    check_val("hole_wr_num", num_data, 32'h0000_0007);
    data_read(HOLE_A, 32'h0, "hole_rd"); step();
    inst_read(32'h0000_0008, 32'hCAFE_0008, "mem_untouched_by_mmio"); step();
    inst_write(NUM_A, 32'h0000_0099); step();
    check_val("inst_no_mmio_num", num_data, 32'h0000_0007);
    inst_read(32'h0000_0008, 32'h0000_0099, "inst_hits_mem"); step();

    // Randomized memory writes with readback through aliased addresses
    for (int i = 0; i < 10; i++) begin
      w = $urandom_range(32'h200, 32'h20F);
      d = $urandom;
      data_write(32'(w) << 2, d); step();
      model_mem[w] = d;
    end
    foreach (model_mem[k]) begin
      a = ($urandom & 32'h0FFF_0003) | (32'(k) << 2);
      inst_read(a, model_mem[k], "rand_rd"); step();
    end

    // Timer load and wrap-around
    data_write(TIMER_A, 32'hFFFF_FFFE); step();
    data_read(TIMER_A, 32'hFFFF_FFFE, "timer_load"); step();
    data_read(TIMER_A, 32'hFFFF_FFFF, "timer_pre_wrap"); step();
    data_read(TIMER_A, 32'h0000_0000, "timer_wrap"); step();
    data_read(TIMER_A, 32'h0000_0001, "timer_after_wrap"); step();

    // Asynchronous reset mid-stream with a read pending
    inst_read(32'h100, 32'hDEAD_BEEF, "pre_rst_inst"); data_read(32'h100, 32'hDEAD_BEEF, "pre_rst_data"); step();
    inst_sram_en = 1'b1; inst_sram_we = 1'b0; inst_sram_addr = 32'h80;
    #2 resetn = 1'b0;
    #1;
    check_val("async_rst_inst", inst_sram_rdata, 32'h0);
    check_val("async_rst_data", data_sram_rdata, 32'h0);
    check_val("async_rst_led", {16'h0, led}, 32'h0);
    check_val("async_rst_num", num_data, 32'h0);
    @(posedge clk);
    #1;
    check_val("rst_pending_discard", inst_sram_rdata, 32'h0);
    inst_sram_en = 1'b0;
    last_inst = '0;
    last_data = '0;
    resetn = 1'b1;
    edges_since_rel = 0;
    inst_read(32'h100, 32'hDEAD_BEEF, "mem_persists_rst"); step();
    data_read(NUM_A, 32'h0, "num_after_rst"); step();
    data_read(SCRATCH_A, 32'h0, "scratch_after_rst"); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
